// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu front end.
//
// Contents
//   CPU_AWIDTH / CPU_IWIDTH : default address and instruction widths
//   CPU_RESET_PC            : default first fetch address after reset
//   fetch_entry_t           : one prefetched instruction tagged with its PC
//                             (default widths; parameterised blocks build
//                             the same layout from their own widths)
//   ptr_width()             : index width for an N-entry storage array
package cpu_pkg;

  localparam int          CPU_AWIDTH   = 16;
  localparam int          CPU_IWIDTH   = 16;
  localparam int unsigned CPU_RESET_PC = 0;

  typedef struct packed {
    logic [CPU_IWIDTH-1:0] instr;
    logic [CPU_AWIDTH-1:0] pc;
  } fetch_entry_t;

  // A one-entry array still needs a one-bit index.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous single-clock FIFO with a combinational read port.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset (pointers and count only)
//   i_flush  synchronous discard of all entries
//   i_push   write i_wdata; accepted when not full, or when full and a
//            pop happens in the same cycle
//   i_wdata  write data
//   i_pop    release the head entry (ignored when empty)
//   o_rdata  head entry (content undefined when empty)
//   o_full   DEPTH entries held
//   o_empty  no entries held
//   o_count  number of entries held
//
// DEPTH need not be a power of two; pointers wrap explicitly.
module fifo_sync
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  // When full, the write lands in the slot the same-cycle pop vacates.
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only and is not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/cpu_ifetch.sv
// cpu_ifetch: instruction-fetch front end with an in-order prefetch queue,
// pipelined request/grant memory reads and branch redirect.
//
// Ports
//   clk            clock
//   reset          synchronous active-high reset
//   mem_rd_o       read request
//   mem_raddr_o    read address (branch target when br_valid_i)
//   mem_gnt_i      request accepted this cycle (with mem_rd_o)
//   mem_rvalid_i   read data valid, in order, >=1 cycle after grant
//   mem_rdata_i    read data
//   hold_i         data side owns the port; blocks new requests only
//   br_valid_i     redirect fetch (one-cycle pulse, highest priority)
//   br_target_i    redirect address
//   ir_o           head instruction (0 when nothing valid)
//   ir_pc_o        PC of head instruction (0 when nothing valid)
//   ir_valid_o     head valid
//   ir_ready_i     decode consumes head when ir_valid_o & ir_ready_i
//
// Build option
//   IFETCH_BYPASS_EN : when defined, a response arriving into an empty
//   queue with nothing to discard and no branch is presented on ir_*
//   combinationally in the same cycle, and is not written to the queue if
//   decode takes it. Undefined (default): outputs come only from the queue.
module cpu_ifetch
  import cpu_pkg::*;
#(
  parameter int          AWIDTH   = CPU_AWIDTH,
  parameter int          IWIDTH   = CPU_IWIDTH,
  parameter int          DEPTH    = 2,
  parameter int          MAX_OUT  = 2,
  parameter int unsigned RESET_PC = CPU_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd_o,
  output logic [AWIDTH-1:0] mem_raddr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [IWIDTH-1:0] mem_rdata_i,
  input  logic              hold_i,
  input  logic              br_valid_i,
  input  logic [AWIDTH-1:0] br_target_i,
  output logic [IWIDTH-1:0] ir_o,
  output logic [AWIDTH-1:0] ir_pc_o,
  output logic              ir_valid_o,
  input  logic              ir_ready_i
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);
  localparam int EW  = IWIDTH + AWIDTH;

  typedef struct packed {
    logic [IWIDTH-1:0] instr;
    logic [AWIDTH-1:0] pc;
  } entry_t;

  // Fetch state
  logic [AWIDTH-1:0] r_fetch_pc;
  logic [OCW-1:0]    r_discard;

  // Outstanding-PC FIFO
  logic              w_grant;
  logic [AWIDTH-1:0] w_pc_head;
  logic              w_pc_full;
  logic              w_pc_empty;
  logic [OCW-1:0]    w_inflight;

  // Prefetch queue
  entry_t            w_q_wdata;
  logic [EW-1:0]     w_q_rdata;
  entry_t            w_q_head;
  logic              w_q_push;
  logic              w_q_pop;
  logic              w_q_full;
  logic              w_q_empty;
  logic [QCW-1:0]    w_q_count;

  // Response / output steering
  logic              w_hit;
  logic              w_bypass;
  logic              w_consume;
  logic [31:0]       w_occ;
  logic              w_unused_flags;

  // ---- issue stage: request only when a queue slot is guaranteed ----
  // Slots already spoken for: held entries plus live in-flight reads
  // (reads marked for discard will never occupy a slot).
  assign w_occ = 32'(w_q_count) + 32'(w_inflight) - 32'(r_discard);

  assign mem_rd_o    = ~reset & ~hold_i & ~w_pc_full & (w_occ < 32'(DEPTH));
  assign mem_raddr_o = br_valid_i ? br_target_i : r_fetch_pc;
  assign w_grant     = mem_rd_o & mem_gnt_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= AWIDTH'(RESET_PC);
      r_discard  <= '0;
    end else begin
      // Wraps modulo 2^AWIDTH through the natural width of the add.
      if (w_grant)         r_fetch_pc <= mem_raddr_o + AWIDTH'(1);
      else if (br_valid_i) r_fetch_pc <= br_target_i;

      // A branch marks every older read still pending as stale; one that
      // returns this very cycle is dropped directly. A read granted in the
      // branch cycle is to the target and is not counted.
      if (br_valid_i)
        r_discard <= w_inflight - OCW'(mem_rvalid_i);
      else if (mem_rvalid_i && (r_discard != '0))
        r_discard <= r_discard - OCW'(1);
    end
  end

  // One entry per read in flight, so its occupancy is the in-flight count.
  fifo_sync #(
    .WIDTH (AWIDTH),
    .DEPTH (MAX_OUT)
  ) u_pc_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_flush (1'b0),
    .i_push  (w_grant),
    .i_wdata (mem_raddr_o),
    .i_pop   (mem_rvalid_i),
    .o_rdata (w_pc_head),
    .o_full  (w_pc_full),
    .o_empty (w_pc_empty),
    .o_count (w_inflight)
  );

  // ---- response stage: keep or drop returning data ----
  assign w_hit = mem_rvalid_i & (r_discard == '0) & ~br_valid_i;

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_hit & w_q_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_wdata.instr = mem_rdata_i;
  assign w_q_wdata.pc    = w_pc_head;

  // A bypassed word taken by decode this cycle never enters the queue.
  assign w_q_push  = w_hit & ~(w_bypass & ir_ready_i);
  assign w_consume = ir_valid_o & ir_ready_i & ~br_valid_i;
  assign w_q_pop   = w_consume & ~w_q_empty;

  fifo_sync #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_prefetch_q (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_flush (br_valid_i),
    .i_push  (w_q_push),
    .i_wdata (w_q_wdata),
    .i_pop   (w_q_pop),
    .o_rdata (w_q_rdata),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  // ---- output stage: queue head, or the bypassed response ----
  assign w_q_head = entry_t'(w_q_rdata);

  always_comb begin
    ir_valid_o = 1'b0;
    ir_o       = '0;
    ir_pc_o    = '0;
    if (w_bypass) begin
      ir_valid_o = 1'b1;
      ir_o       = mem_rdata_i;
      ir_pc_o    = w_pc_head;
    end else if (!w_q_empty) begin
      ir_valid_o = 1'b1;
      ir_o       = w_q_head.instr;
      ir_pc_o    = w_q_head.pc;
    end
  end

  // Status flags the control logic does not need; the in-flight limit and
  // slot reservation already imply them.
  assign w_unused_flags = w_q_full ^ w_pc_empty;

endmodule
